joypad_ctrl: RTL
================

# joypad_ctrl

Joypad controller for the GameBoy IO subsystem. Debounces the eight raw button inputs, implements the CPU-visible P1 register at 0xFF00 (select bits 5:4, active-low key nibble 3:0), and raises the joypad interrupt request with a hold-until-acknowledge handshake. It sits between the board button inputs and the CPU memory bus and interrupt controller.

## Interface

- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a raw input change is accepted; minimum 2.
- `P1_ADDR`, 16'hFF00: bus address of the P1 register.

- `Clock`  in  1  system clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-low reset; 0 = reset.
- `iButtons`  in  8  raw buttons, 1 = pressed; bit order {START, SELECT, B, A, DOWN, UP, LEFT, RIGHT} (7..0); asynchronous to `Clock`.
- `iAddr`  in  16  CPU bus address.
- `iData`  in  8  CPU write data.
- `iWe`  in  1  write strobe, one cycle.
- `iRe`  in  1  read strobe, one cycle.
- `oData`  out  8  read data.
- `oDataValid`  out  1  one-cycle pulse qualifying `oData`.
- `oIrq`  out  1  joypad interrupt request, level.
- `iIrqAck`  in  1  interrupt acknowledge, one cycle.

## Operation

- **Input sync.** Each `iButtons` bit passes through a 2-flop synchronizer, then its debouncer.
- **Debounce, per bit.**
  - Keeps a stable state and a counter.
  - Counter clears whenever the synced input equals the stable state.
  - Counter increments while they differ.
  - At count `DEBOUNCE_CYCLES-1`, the stable state takes the input and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES); the counter never wraps.
- **Select register `rSel[1:0]`.**
  - Written from `iData[5:4]` when `iWe` is high and `iAddr==P1_ADDR`.
  - Other data bits are ignored.
  - Writes to other addresses are ignored.
- **Key nibble, active-low.**
  - Direction term `dirs` = {DOWN, UP, LEFT, RIGHT}, included when `rSel[0]==0`.
  - Button term `btns` = {START, SELECT, B, A}, included when `rSel[1]==0`.
  - nibble = ~(dirs_term | btns_term), using debounced values. Both selected ORs them; neither selected gives 4'hF.
- **Read.** When `iRe` is high and `iAddr==P1_ADDR`, `oData` = {2'b11, rSel, nibble} with `oDataValid` high the next cycle. Other addresses produce no `oDataValid`.
- **Interrupt.**
  - A registered copy of the nibble is compared each cycle.
  - Any bit going 1→0 sets `pending`. This includes a falling bit caused by an `rSel` write.
  - `oIrq` = `pending`.
  - `iIrqAck` clears `pending`. If a new falling edge coincides with the ack, `pending` stays 1.
  - Rising bits (releases) never interrupt.
- **Simultaneous access.** `iWe` and `iRe` in the same cycle to P1: the read returns the old `rSel`; the write takes effect afterwards.

## Timing

- **Reset values:** `oData`=8'hFF, `oDataValid`=0, `oIrq`=0, `rSel`=2'b11, debounced state all 0, counters 0, previous nibble 4'hF.
- **Reset mid-debounce:** the counter discards progress. After reset release, a held button needs the full sync + debounce time again.
- **Press latency:** raw edge → debounced state = 2 sync cycles + `DEBOUNCE_CYCLES` cycles. Debounced change → `oIrq` high one cycle later.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` synced cycles never changes the debounced state.
- **Read latency:** 1 cycle; back-to-back reads are supported every cycle.
- **Write visibility:** a write is visible to a read strobed the next cycle.

## Configuration

- **`JOYPAD_DEBOUNCE_EN` defined:** debounce logic as described above.
- **`JOYPAD_DEBOUNCE_EN` undefined:**
  - Debouncers are removed; the debounced state equals the synchronizer output.
  - Press latency is 2 cycles.
  - `DEBOUNCE_CYCLES` is ignored.

## Structure

- **Shared package `joypad_pkg`:**
  - `P1_ADDR` default.
  - Button bit indices (`BTN_RIGHT`=0 … `BTN_START`=7).
  - Select encodings: `SEL_DIR`=2'b10, `SEL_BTN`=2'b01, `SEL_NONE`=2'b11, `SEL_BOTH`=2'b00.
  - Reset constants.
- **Sub-module `joypad_debounce`:** one bit with synchronizer and counter, parameterised by `DEBOUNCE_CYCLES`; instantiated 8×.
- The top level holds the select register, nibble mux, read port and interrupt FSM.

## Test plan

Bench uses `DEBOUNCE_CYCLES`=4.

1. **Reset:** hold `Reset`=0, then read 0xFF00 → `oData`=8'hFF, `oIrq`=0.
2. **Direction press:** write 8'h20 (`SEL_DIR`), press RIGHT for 10 cycles → `oIrq` high 7 cycles after the press; read returns 8'hEE; ack → `oIrq`=0.
3. **Glitch rejection:** 3-cycle pulse on A with `SEL_BTN` → no `oIrq`; read returns 8'hDF.
4. **Select change interrupts:** hold B with `SEL_DIR` (no irq), then write 8'h10 → `oIrq` high next cycle; read returns 8'hDD.
5. **Ack collision:** `iIrqAck` in the same cycle as a new DOWN press edge → `oIrq` stays 1.
6. **Reset mid-operation:** assert `Reset` mid-debounce with LEFT held → all outputs at reset values; LEFT is reported 6 cycles after release.

Source files
------------

// File: rtl/joypad_pkg.sv
// Shared constants for the joypad controller: P1 address, button bit indices,
// select encodings, reset values and the active-low key nibble helper.
package joypad_pkg;

  localparam logic [15:0] DEFAULT_P1_ADDR = 16'hFF00;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_SELECT = 6;
  localparam int BTN_START  = 7;

  localparam logic [1:0] SEL_DIR  = 2'b10;
  localparam logic [1:0] SEL_BTN  = 2'b01;
  localparam logic [1:0] SEL_NONE = 2'b11;
  localparam logic [1:0] SEL_BOTH = 2'b00;

  localparam logic [1:0] RST_SEL    = SEL_NONE;
  localparam logic [7:0] RST_DATA   = 8'hFF;
  localparam logic [3:0] RST_NIBBLE = 4'hF;

  typedef enum logic {
    IRQ_IDLE,
    IRQ_PENDING
  } irq_state_e;

  // A select bit of 0 enables its group; pressed keys read back as 0.
  function automatic logic [3:0] key_nibble(input logic [1:0] sel, input logic [7:0] btn);
    logic [3:0] dirs;
    logic [3:0] btns;
    dirs = {btn[BTN_DOWN], btn[BTN_UP], btn[BTN_LEFT], btn[BTN_RIGHT]};
    btns = {btn[BTN_START], btn[BTN_SELECT], btn[BTN_B], btn[BTN_A]};
    case (sel)
      SEL_DIR:  return ~dirs;
      SEL_BTN:  return ~btns;
      SEL_BOTH: return ~(dirs | btns);
      default:  return RST_NIBBLE;
    endcase
  endfunction

endpackage

// File: rtl/joypad_debounce.sv
// One button bit: 2-flop synchronizer followed by a stable-count debouncer.
// The debouncer exists only when JOYPAD_DEBOUNCE_EN is defined.
module joypad_debounce
  import joypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic button,
  output logic stable
);

  logic sync_meta;
  logic sync_out;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= button;
      sync_out  <= sync_meta;
    end
  end

`ifdef JOYPAD_DEBOUNCE_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // Counts below the 2-cycle minimum cannot be filtered and fall back to pass-through.
  generate
    if (FILTER_EN && DEBOUNCE_CYCLES >= 2) begin : g_filter
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt;
      logic             state;

      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          cnt   <= '0;
          state <= 1'b0;
        end else if (sync_out == state) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt   <= '0;
          state <= sync_out;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign stable = state;
    end else begin : g_bypass
      assign stable = sync_out;
    end
  endgenerate

endmodule

// File: rtl/joypad_ctrl.sv
// GameBoy joypad controller: P1 register (select + active-low key nibble) and
// joypad interrupt with hold-until-ack. Build macro JOYPAD_DEBOUNCE_EN adds debouncing.
module joypad_ctrl
  import joypad_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] P1_ADDR         = DEFAULT_P1_ADDR
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  iButtons,
  input  logic [15:0] iAddr,
  input  logic [7:0]  iData,
  input  logic        iWe,
  input  logic        iRe,
  output logic [7:0]  oData,
  output logic        oDataValid,
  output logic        oIrq,
  input  logic        iIrqAck
);

  logic [7:0] debounced;
  logic [1:0] sel;
  logic [3:0] nibble;
  logic [3:0] prev_nibble;
  logic       p1_hit;
  logic       falling;
  logic       data_unused;
  irq_state_e irq_state;
  irq_state_e irq_next;

  for (genvar i = 0; i < 8; i++) begin : g_btn
    joypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .Clock (Clock),
      .Reset (Reset),
      .button(iButtons[i]),
      .stable(debounced[i])
    );
  end

  assign p1_hit      = (iAddr == P1_ADDR);
  assign nibble      = key_nibble(sel, debounced);
  assign data_unused = ^{iData[7:6], iData[3:0]};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sel <= RST_SEL;
    end else if (iWe && p1_hit) begin
      sel <= iData[5:4];
    end
  end

  // Read data samples the pre-write select, so a same-cycle write lands afterwards.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oData      <= RST_DATA;
      oDataValid <= 1'b0;
    end else begin
      oDataValid <= iRe && p1_hit;
      if (iRe && p1_hit) begin
        oData <= {2'b11, sel, nibble};
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      irq_state   <= IRQ_IDLE;
      prev_nibble <= RST_NIBBLE;
    end else begin
      irq_state   <= irq_next;
      prev_nibble <= nibble;
    end
  end

  // A new press edge outranks an acknowledge arriving in the same cycle.
  always_comb begin
    irq_next = irq_state;
    falling  = |(prev_nibble & ~nibble);
    case (irq_state)
      IRQ_IDLE:    if (falling) irq_next = IRQ_PENDING;
      IRQ_PENDING: if (iIrqAck && !falling) irq_next = IRQ_IDLE;
    endcase
  end

  assign oIrq = (irq_state == IRQ_PENDING);

endmodule
